dma_sram_responder: RTL and testbench

- Bus-target side for motherboard-initiated DMA cycles into the on-card fast SRAM.
- Active only while a Zorro II / motherboard master owns the bus (68SEC000 has released it).
- Synchronises the asynchronous 68000 strobes into the pll_inst1_CLKOUT0 domain, decodes the configured RAM window, and drives the SRAM bank strobes.
- Returns DTACK to the motherboard master and releases it cleanly at end of cycle; its strobe outputs are ORed with the CPU-side RAM controller's strobes at the top level.

---
 rtl/dma_pkg.sv | 17 +
 rtl/sync_bit.sv | 25 ++
 rtl/dma_sram_responder.sv | 205 ++++++++++++++++++++
 tb/tb_dma_sram_responder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared state encoding and window constants for the DMA SRAM responder
package dma_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_ACK,
        S_REL,
        S_END
    } dma_state_e;

    // Window size in 4 MB slots, selected by JP4.
    localparam logic [1:0] SLOT_4MB = 2'd1;
    localparam logic [1:0] SLOT_8MB = 2'd2;

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-stage synchroniser for an active-low strobe, presets to 1 on reset
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    localparam int N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] chain_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            chain_q <= '1;
        end else begin
            chain_q <= {chain_q[N-2:0], d_i};
        end
    end

    assign q_o = chain_q[N-1];

endmodule

// File: rtl/dma_sram_responder.sv
// rtl/dma_sram_responder.sv - bus-target FSM servicing motherboard DMA cycles into on-card SRAM
module dma_sram_responder
    import dma_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int RD_WAIT     = 3,
    parameter int WR_PULSE    = 3,
    parameter int TIMEOUT     = 255
) (
    input  logic       pll_inst1_CLKOUT0,
    input  logic       RESET_n,
    input  logic       DMA_ACTIVE,
    input  logic       AS_MB_n,
    input  logic       UDS_n,
    input  logic       LDS_n,
    input  logic       RW_n,
    input  logic [2:0] A_HIGH,
    input  logic [2:0] BASE_RAM,
    input  logic       RAM_CONFIGURED_n,
    input  logic       JP4,
    output logic       OE_BANK0_n,
    output logic       OE_BANK1_n,
    output logic       WE_BANK0_EVEN_n,
    output logic       WE_BANK0_ODD_n,
    output logic       WE_BANK1_EVEN_n,
    output logic       WE_BANK1_ODD_n,
    output logic       DTACK_OUT_n,
    output logic       DTACK_OE,
    output logic       DMA_HIT
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LEN  = CNT_W'(WR_PULSE);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic as_s, uds_s, lds_s;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_as (
        .clk_i(pll_inst1_CLKOUT0), .rst_n_i(RESET_n), .d_i(AS_MB_n), .q_o(as_s)
    );
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_uds (
        .clk_i(pll_inst1_CLKOUT0), .rst_n_i(RESET_n), .d_i(UDS_n), .q_o(uds_s)
    );
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lds (
        .clk_i(pll_inst1_CLKOUT0), .rst_n_i(RESET_n), .d_i(LDS_n), .q_o(lds_s)
    );

    // Window decode works on 4 MB slots (A[23:22]); slot arithmetic never wraps past slot 3.
    logic [1:0] a_slot, b_slot, slot_off, slot_cnt;
    logic       win_match, bank_sel, hit;
    logic       unused_base_lsb;

    assign a_slot          = A_HIGH[2:1];
    assign b_slot          = BASE_RAM[2:1];
    assign slot_off        = a_slot - b_slot;
    assign slot_cnt        = JP4 ? SLOT_8MB : SLOT_4MB;
    assign win_match       = (a_slot >= b_slot) && (slot_off < slot_cnt);
    assign bank_sel        = JP4 ? slot_off[0] : A_HIGH[0];
    assign hit             = DMA_ACTIVE && !RAM_CONFIGURED_n && win_match;
    assign unused_base_lsb = BASE_RAM[0];

    dma_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bank_q, bank_d;
    logic             rd_q, rd_d;
    logic             uds_q, uds_d;
    logic             lds_q, lds_d;
    logic [1:0]       oe_q, oe_d;
    logic [3:0]       we_q, we_d;
    logic             dtack_n_q, dtack_n_d;
    logic             dtack_oe_q, dtack_oe_d;
    logic             hit_q, hit_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        rd_d    = rd_q;
        uds_d   = uds_q;
        lds_d   = lds_q;

        case (state_q)
            S_IDLE: begin
                if (!as_s && (!uds_s || !lds_s)) begin
                    if (hit) begin
                        state_d = RW_n ? S_RD : S_WR;
                        bank_d  = bank_sel;
                        rd_d    = RW_n;
                        uds_d   = !uds_s;
                        lds_d   = !lds_s;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_END;
                    end
                end
            end
            S_RD: begin
                if (as_s || !DMA_ACTIVE) begin
                    state_d = S_REL;
                end else if (cnt_q == RD_LAST) begin
                    state_d = S_ACK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WR: begin
                // Final count is the WE recovery cycle before DTACK.
                if (as_s || !DMA_ACTIVE) begin
                    state_d = S_REL;
                end else if (cnt_q == WR_LEN) begin
                    state_d = S_ACK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACK: begin
                if (as_s || !DMA_ACTIVE || (cnt_q == TO_LAST)) begin
                    state_d = S_REL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REL: state_d = S_END;
            S_END: begin
                if (as_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so the pads come straight off flops.
        oe_d       = 2'b11;
        we_d       = 4'b1111;
        dtack_n_d  = 1'b1;
        dtack_oe_d = 1'b0;
        hit_d      = 1'b0;

        case (state_d)
            S_RD: begin
                hit_d        = 1'b1;
                oe_d[bank_d] = 1'b0;
            end
            S_WR: begin
                hit_d = 1'b1;
                if (cnt_d < WR_LEN) begin
                    we_d[{bank_d, 1'b0}] = !uds_d;
                    we_d[{bank_d, 1'b1}] = !lds_d;
                end
            end
            S_ACK: begin
                hit_d      = 1'b1;
                dtack_n_d  = 1'b0;
                dtack_oe_d = 1'b1;
                if (rd_d) begin
                    oe_d[bank_d] = 1'b0;
                end
            end
            S_REL: dtack_oe_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge pll_inst1_CLKOUT0 or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bank_q     <= 1'b0;
            rd_q       <= 1'b1;
            uds_q      <= 1'b0;
            lds_q      <= 1'b0;
            oe_q       <= 2'b11;
            we_q       <= 4'b1111;
            dtack_n_q  <= 1'b1;
            dtack_oe_q <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bank_q     <= bank_d;
            rd_q       <= rd_d;
            uds_q      <= uds_d;
            lds_q      <= lds_d;
            oe_q       <= oe_d;
            we_q       <= we_d;
            dtack_n_q  <= dtack_n_d;
            dtack_oe_q <= dtack_oe_d;
            hit_q      <= hit_d;
        end
    end

    assign OE_BANK0_n      = oe_q[0];
    assign OE_BANK1_n      = oe_q[1];
    assign WE_BANK0_EVEN_n = we_q[0];
    assign WE_BANK0_ODD_n  = we_q[1];
    assign WE_BANK1_EVEN_n = we_q[2];
    assign WE_BANK1_ODD_n  = we_q[3];
    assign DTACK_OUT_n     = dtack_n_q;
    assign DTACK_OE        = dtack_oe_q;
    assign DMA_HIT         = hit_q;

endmodule

// File: tb/tb_dma_sram_responder.sv
// tb/tb_dma_sram_responder.sv - directed self-checking bench for dma_sram_responder
module tb_dma_sram_responder;

    logic       clk;
    logic       RESET_n;
    logic       DMA_ACTIVE;
    logic       AS_MB_n;
    logic       UDS_n;
    logic       LDS_n;
    logic       RW_n;
    logic [2:0] A_HIGH;
    logic [2:0] BASE_RAM;
    logic       RAM_CONFIGURED_n;
    logic       JP4;
    logic       OE_BANK0_n, OE_BANK1_n;
    logic       WE_BANK0_EVEN_n, WE_BANK0_ODD_n, WE_BANK1_EVEN_n, WE_BANK1_ODD_n;
    logic       DTACK_OUT_n, DTACK_OE, DMA_HIT;

    dma_sram_responder dut (
        .pll_inst1_CLKOUT0(clk),
        .RESET_n(RESET_n),
        .DMA_ACTIVE(DMA_ACTIVE),
        .AS_MB_n(AS_MB_n),
        .UDS_n(UDS_n),
        .LDS_n(LDS_n),
        .RW_n(RW_n),
        .A_HIGH(A_HIGH),
        .BASE_RAM(BASE_RAM),
        .RAM_CONFIGURED_n(RAM_CONFIGURED_n),
        .JP4(JP4),
        .OE_BANK0_n(OE_BANK0_n),
        .OE_BANK1_n(OE_BANK1_n),
        .WE_BANK0_EVEN_n(WE_BANK0_EVEN_n),
        .WE_BANK0_ODD_n(WE_BANK0_ODD_n),
        .WE_BANK1_EVEN_n(WE_BANK1_EVEN_n),
        .WE_BANK1_ODD_n(WE_BANK1_ODD_n),
        .DTACK_OUT_n(DTACK_OUT_n),
        .DTACK_OE(DTACK_OE),
        .DMA_HIT(DMA_HIT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int dt_at;
    int oe_lo [2];
    int we_lo [4];
    int dtoe_n;
    int hit_n;
    int overlap = 0;
    int ack_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Samples n cycles; strobe-low counts only accumulate while DTACK is high.
    task automatic measure(input int n);
        dt_at  = -1;
        oe_lo  = '{0, 0};
        we_lo  = '{0, 0, 0, 0};
        dtoe_n = 0;
        hit_n  = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (DTACK_OUT_n === 1'b0 && dt_at < 0) dt_at = i;
            if (DTACK_OUT_n === 1'b1) begin
                if (OE_BANK0_n === 1'b0) oe_lo[0]++;
                if (OE_BANK1_n === 1'b0) oe_lo[1]++;
                if (WE_BANK0_EVEN_n === 1'b0) we_lo[0]++;
                if (WE_BANK0_ODD_n === 1'b0) we_lo[1]++;
                if (WE_BANK1_EVEN_n === 1'b0) we_lo[2]++;
                if (WE_BANK1_ODD_n === 1'b0) we_lo[3]++;
            end
            if (DTACK_OE === 1'b1) dtoe_n++;
            if (DMA_HIT === 1'b1) hit_n++;
            if (!(OE_BANK0_n && OE_BANK1_n) &&
                !(WE_BANK0_EVEN_n && WE_BANK0_ODD_n && WE_BANK1_EVEN_n && WE_BANK1_ODD_n))
                overlap++;
        end
    endtask

    function automatic int strobe_total();
        return oe_lo[0] + oe_lo[1] + we_lo[0] + we_lo[1] + we_lo[2] + we_lo[3];
    endfunction

    task automatic start_cycle(input logic rw, input logic [2:0] a, input logic uds, input logic lds);
        RW_n    = rw;
        A_HIGH  = a;
        UDS_n   = uds;
        LDS_n   = lds;
        AS_MB_n = 1'b0;
    endtask

    task automatic end_cycle();
        AS_MB_n = 1'b1;
        UDS_n   = 1'b1;
        LDS_n   = 1'b1;
        repeat (6) tick();
    endtask

    initial begin
        RESET_n          = 1'b0;
        DMA_ACTIVE       = 1'b1;
        AS_MB_n          = 1'b1;
        UDS_n            = 1'b1;
        LDS_n            = 1'b1;
        RW_n             = 1'b1;
        A_HIGH           = 3'b000;
        BASE_RAM         = 3'b010;
        RAM_CONFIGURED_n = 1'b0;
        JP4              = 1'b0;

        repeat (3) tick();
        chk("rst_strobes", {OE_BANK0_n, OE_BANK1_n, WE_BANK0_EVEN_n, WE_BANK0_ODD_n,
                            WE_BANK1_EVEN_n, WE_BANK1_ODD_n}, 32'h3f);
        chk("rst_dtack_n", DTACK_OUT_n, 1);
        chk("rst_dtack_oe", DTACK_OE, 0);
        chk("rst_hit", DMA_HIT, 0);
        RESET_n = 1'b1;
        repeat (2) tick();

        // Read, 4 MB window, upper bank
        start_cycle(1'b1, 3'b011, 1'b0, 1'b0);
        measure(6);
        chk("rd_latency", dt_at, 6);
        chk("rd_oe1_cycles", oe_lo[1], 3);
        chk("rd_oe0_cycles", oe_lo[0], 0);
        chk("rd_oe1_in_ack", OE_BANK1_n, 0);
        chk("rd_hit", DMA_HIT, 1);
        AS_MB_n = 1'b1;
        UDS_n   = 1'b1;
        LDS_n   = 1'b1;
        repeat (2) tick();
        chk("rd_ack_hold", DTACK_OUT_n, 0);
        tick();
        chk("rel_dtack_n", DTACK_OUT_n, 1);
        chk("rel_dtack_oe", DTACK_OE, 1);
        chk("rel_oe1", OE_BANK1_n, 1);
        chk("rel_hit", DMA_HIT, 0);
        tick();
        chk("end_dtack_oe", DTACK_OE, 0);
        repeat (3) tick();

        // Write, UDS only, lower bank
        start_cycle(1'b0, 3'b010, 1'b0, 1'b1);
        measure(8);
        chk("wr_latency", dt_at, 7);
        chk("wr_we0_even_cycles", we_lo[0], 3);
        chk("wr_we0_odd_cycles", we_lo[1], 0);
        chk("wr_bank1_we", we_lo[2] + we_lo[3], 0);
        chk("wr_no_oe", oe_lo[0] + oe_lo[1], 0);
        chk("wr_we_in_ack", WE_BANK0_EVEN_n, 1);
        end_cycle();

        // Unconfigured board: no response at all
        RAM_CONFIGURED_n = 1'b1;
        start_cycle(1'b1, 3'b011, 1'b0, 1'b0);
        measure(12);
        chk("miss_cfg_strobes", strobe_total(), 0);
        chk("miss_cfg_dtack_oe", dtoe_n, 0);
        chk("miss_cfg_hit", hit_n, 0);
        end_cycle();
        RAM_CONFIGURED_n = 1'b0;

        // Bus not granted to an external master
        DMA_ACTIVE = 1'b0;
        start_cycle(1'b0, 3'b010, 1'b0, 1'b0);
        measure(12);
        chk("miss_dma_strobes", strobe_total(), 0);
        chk("miss_dma_dtack_oe", dtoe_n, 0);
        end_cycle();
        DMA_ACTIVE = 1'b1;

        // 8 MB window: second slot maps to bank 1
        JP4 = 1'b1;
        start_cycle(1'b1, 3'b100, 1'b0, 1'b0);
        measure(6);
        chk("w8_slot2_latency", dt_at, 6);
        chk("w8_slot2_oe1", oe_lo[1], 3);
        end_cycle();

        // 8 MB window, third slot is outside
        start_cycle(1'b1, 3'b110, 1'b0, 1'b0);
        measure(12);
        chk("w8_slot3_miss", dtoe_n + strobe_total(), 0);
        end_cycle();

        // Base at top slot: own slot hits bank 0, slot 0 must not wrap in
        BASE_RAM = 3'b110;
        start_cycle(1'b1, 3'b111, 1'b0, 1'b0);
        measure(6);
        chk("w8_top_oe0", oe_lo[0], 3);
        end_cycle();
        start_cycle(1'b1, 3'b000, 1'b0, 1'b0);
        measure(12);
        chk("w8_nowrap_miss", dtoe_n + strobe_total(), 0);
        end_cycle();
        BASE_RAM = 3'b010;
        JP4      = 1'b0;

        // Master hangs on AS: forced release after TIMEOUT cycles
        start_cycle(1'b1, 3'b011, 1'b0, 1'b0);
        measure(6);
        chk("to_latency", dt_at, 6);
        ack_cnt = 1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (DTACK_OUT_n === 1'b0) ack_cnt++;
            else break;
        end
        chk("to_ack_cycles", ack_cnt, 255);
        chk("to_rel_dtack_oe", DTACK_OE, 1);
        chk("to_rel_dtack_n", DTACK_OUT_n, 1);
        tick();
        chk("to_end_dtack_oe", DTACK_OE, 0);
        measure(40);
        chk("to_end_quiet", dtoe_n + hit_n + strobe_total(), 0);
        end_cycle();
        start_cycle(1'b1, 3'b011, 1'b0, 1'b0);
        measure(6);
        chk("post_to_latency", dt_at, 6);
        end_cycle();

        // AS withdrawn early in a write pulse
        start_cycle(1'b0, 3'b010, 1'b0, 1'b0);
        repeat (2) tick();
        AS_MB_n = 1'b1;
        UDS_n   = 1'b1;
        LDS_n   = 1'b1;
        measure(8);
        chk("abort_we_even", we_lo[0], 2);
        chk("abort_we_odd", we_lo[1], 2);
        chk("abort_no_dtack", dt_at, -1);
        chk("abort_rel_pulse", dtoe_n, 1);
        repeat (3) tick();

        // Reset asserted while acknowledging, AS kept low across it
        start_cycle(1'b1, 3'b011, 1'b0, 1'b0);
        measure(6);
        chk("rstmid_pre_latency", dt_at, 6);
        RESET_n = 1'b0;
        #2;
        chk("rstmid_dtack_oe", DTACK_OE, 0);
        chk("rstmid_dtack_n", DTACK_OUT_n, 1);
        chk("rstmid_hit", DMA_HIT, 0);
        chk("rstmid_strobes", {OE_BANK0_n, OE_BANK1_n, WE_BANK0_EVEN_n, WE_BANK0_ODD_n,
                               WE_BANK1_EVEN_n, WE_BANK1_ODD_n}, 32'h3f);
        tick();
        RESET_n = 1'b1;
        measure(6);
        chk("rstmid_resume_latency", dt_at, 6);
        chk("rstmid_resume_oe1", oe_lo[1], 3);
        end_cycle();

        chk("oe_we_overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
